ded_fsq_ctl: RTL and testbench

Funnel-shift sequencer for the drawing-engine datapath. It accepts one bit-granular copy command (source bit address, destination bit address, length) and breaks it into per-destination-word beats. Each beat carries the source cache word address for the bsd0/bsd1 pair, the rad shift amount, the destination word address, a destination bit mask and first/last flags. It sits between the DE command/address logic and the funnel shifter / color selector, pacing them with a valid/ready handshake.

---
 rtl/ded_fsq_pkg.sv | 35 +++
 rtl/ded_fsq_ctl_msk.sv | 36 +++
 rtl/ded_fsq_ctl.sv | 166 ++++++++++++++++
 tb/tb_ded_fsq_ctl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ded_fsq_pkg.sv
// Shared types and helpers for the funnel-shift sequencer.
package ded_fsq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fsq_state_e;

  localparam int unsigned MAXW = 128;

  function automatic int unsigned word_bits(input int unsigned bytes);
    return bytes * 8;
  endfunction

  function automatic int unsigned log2w(input int unsigned w);
    return $clog2(w);
  endfunction

  // Bits MAXW-1..n set; callers truncate to their word width.
  function automatic logic [MAXW-1:0] lo_msk(input logic [6:0] n);
    logic [MAXW-1:0] m;
    m = '1;
    return m << n;
  endfunction

  // Bits n..0 set.
  function automatic logic [MAXW-1:0] hi_msk(input logic [6:0] n);
    logic [MAXW-1:0] m;
    m = '1;
    m = (m << n) << 1;
    return ~m;
  endfunction

endpackage

// File: rtl/ded_fsq_ctl_msk.sv
// Destination mask generator: combines first/last edge masks, registered.
module ded_fsq_msk
  import ded_fsq_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter int unsigned RADW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            is_first,
  input  logic            is_last,
  input  logic [RADW-1:0] lo_n,
  input  logic [RADW-1:0] hi_n,
  output logic [W-1:0]    msk
);

  logic [W-1:0] msk_d, msk_q;

  always_comb begin
    msk_d = msk_q;
    if (en) begin
      msk_d = '1;
      if (is_first) msk_d = msk_d & W'(lo_msk(7'(lo_n)));
      if (is_last)  msk_d = msk_d & W'(hi_msk(7'(hi_n)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) msk_q <= '0;
    else       msk_q <= msk_d;
  end

  assign msk = msk_q;

endmodule

// File: rtl/ded_fsq_ctl.sv
// Funnel-shift sequencer: splits a bit-granular copy command into
// per-destination-word beats for the funnel shifter.
module ded_fsq_ctl
  import ded_fsq_pkg::*;
#(
  parameter int unsigned BYTES = 4,
  parameter int unsigned AW    = 16
) (
  input  logic                                       mclock,
  input  logic                                       reset,
  input  logic                                       cmd_vld,
  output logic                                       cmd_rdy,
  input  logic [AW-1:0]                              cmd_sadr,
  input  logic [AW-1:0]                              cmd_dadr,
  input  logic [AW-1:0]                              cmd_len,
  output logic                                       out_vld,
  input  logic                                       out_rdy,
  output logic [AW-log2w(word_bits(BYTES))-1:0]      rd_adr,
  output logic [log2w(word_bits(BYTES))-1:0]         rad,
  output logic [AW-log2w(word_bits(BYTES))-1:0]      dst_adr,
  output logic [word_bits(BYTES)-1:0]                dst_msk,
  output logic                                       first,
  output logic                                       last,
  output logic                                       busy
);

  localparam int unsigned W    = word_bits(BYTES);
  localparam int unsigned RADW = log2w(W);
  localparam int unsigned WAW  = AW - RADW;

  fsq_state_e     state_d, state_q;
  logic [AW-1:0]  sadr_d, sadr_q, dadr_d, dadr_q, len_d, len_q;
  logic [WAW-1:0] rd_adr_d, rd_adr_q, dst_adr_d, dst_adr_q, rem_d, rem_q;
  logic [RADW-1:0] rad_d, rad_q;
  logic           first_d, first_q, last_d, last_q;
  logic           out_vld_d, out_vld_q, cmd_rdy_d, cmd_rdy_q, busy_d, busy_q;

  logic [AW-1:0]  delta, end_bit;
  logic [WAW-1:0] d0, dn, s0;
  logic           msk_en, msk_first, msk_last;

  // Latched command stays stable for the whole command, so these are
  // valid in LOAD and RUN alike.
  always_comb begin
    delta   = sadr_q - dadr_q;
    end_bit = dadr_q + len_q - AW'(1);
    d0      = dadr_q[AW-1:RADW];
    dn      = end_bit[AW-1:RADW];
    s0      = WAW'(({d0, {RADW{1'b0}}} + delta) >> RADW);
  end

  always_comb begin
    state_d   = state_q;
    sadr_d    = sadr_q;
    dadr_d    = dadr_q;
    len_d     = len_q;
    rd_adr_d  = rd_adr_q;
    dst_adr_d = dst_adr_q;
    rem_d     = rem_q;
    rad_d     = rad_q;
    first_d   = first_q;
    last_d    = last_q;
    msk_en    = 1'b0;
    msk_first = 1'b0;
    msk_last  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_vld && cmd_len != '0) begin
          sadr_d  = cmd_sadr;
          dadr_d  = cmd_dadr;
          len_d   = cmd_len;
          state_d = LOAD;
        end
      end
      LOAD: begin
        rad_d     = delta[RADW-1:0];
        rd_adr_d  = s0;
        dst_adr_d = d0;
        rem_d     = dn - d0;
        first_d   = 1'b1;
        last_d    = (dn == d0);
        msk_en    = 1'b1;
        msk_first = 1'b1;
        msk_last  = (dn == d0);
        state_d   = RUN;
      end
      RUN: begin
        if (out_rdy) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            rd_adr_d  = rd_adr_q + WAW'(1);
            dst_adr_d = dst_adr_q + WAW'(1);
            rem_d     = rem_q - WAW'(1);
            first_d   = 1'b0;
            last_d    = (rem_q == WAW'(1));
            msk_en    = 1'b1;
            msk_last  = (rem_q == WAW'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_rdy_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    out_vld_d = (state_d == RUN);
  end

  always_ff @(posedge mclock) begin
    if (reset) begin
      state_q   <= IDLE;
      sadr_q    <= '0;
      dadr_q    <= '0;
      len_q     <= '0;
      rd_adr_q  <= '0;
      dst_adr_q <= '0;
      rem_q     <= '0;
      rad_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      out_vld_q <= 1'b0;
      cmd_rdy_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sadr_q    <= sadr_d;
      dadr_q    <= dadr_d;
      len_q     <= len_d;
      rd_adr_q  <= rd_adr_d;
      dst_adr_q <= dst_adr_d;
      rem_q     <= rem_d;
      rad_q     <= rad_d;
      first_q   <= first_d;
      last_q    <= last_d;
      out_vld_q <= out_vld_d;
      cmd_rdy_q <= cmd_rdy_d;
      busy_q    <= busy_d;
    end
  end

  ded_fsq_msk #(
    .W    (W),
    .RADW (RADW)
  ) u_msk (
    .clk      (mclock),
    .reset    (reset),
    .en       (msk_en),
    .is_first (msk_first),
    .is_last  (msk_last),
    .lo_n     (dadr_q[RADW-1:0]),
    .hi_n     (end_bit[RADW-1:0]),
    .msk      (dst_msk)
  );

  assign cmd_rdy = cmd_rdy_q;
  assign out_vld = out_vld_q;
  assign rd_adr  = rd_adr_q;
  assign rad     = rad_q;
  assign dst_adr = dst_adr_q;
  assign first   = first_q;
  assign last    = last_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ded_fsq_ctl.sv
// Directed and randomized checks of ded_fsq_ctl against an arithmetic beat model.
module tb_ded_fsq_ctl;

  localparam int unsigned AW  = 16;
  localparam int unsigned WAW = 11;

  logic          mclock = 1'b0;
  logic          reset, cmd_vld, cmd_rdy, out_vld, out_rdy;
  logic [15:0]   cmd_sadr, cmd_dadr, cmd_len;
  logic [10:0]   rd_adr, dst_adr;
  logic [4:0]    rad;
  logic [31:0]   dst_msk;
  logic          first, last, busy;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 mclock = ~mclock;

  ded_fsq_ctl #(.BYTES(4), .AW(AW)) dut (
    .mclock   (mclock),
    .reset    (reset),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_sadr (cmd_sadr),
    .cmd_dadr (cmd_dadr),
    .cmd_len  (cmd_len),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .rd_adr   (rd_adr),
    .rad      (rad),
    .dst_adr  (dst_adr),
    .dst_msk  (dst_msk),
    .first    (first),
    .last     (last),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclock);
    #1;
  endtask

  task automatic issue(input int unsigned s, input int unsigned d, input int unsigned l);
    int unsigned guard;
    guard = 0;
    while (cmd_rdy !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    chk("issue_rdy", cmd_rdy, 1);
    cmd_sadr = 16'(s);
    cmd_dadr = 16'(d);
    cmd_len  = 16'(l);
    cmd_vld  = 1'b1;
    tick();
    cmd_vld  = 1'b0;
  endtask

  // Called right after the accept edge; checks every cycle until the last beat.
  task automatic collect(input int unsigned s, input int unsigned d, input int unsigned l,
                         input int stall_at, input int stall_n, input bit rnd);
    int unsigned delta, e, d0, dn, nb, k, cyc, stalls, dst, rdw, m, tmp;
    bit rdy;
    delta = (s + 65536 - d) % 65536;
    e     = (d + l + 65536 - 1) % 65536;
    d0    = d / 32;
    dn    = e / 32;
    nb    = ((dn + 2048 - d0) % 2048) + 1;
    chk("load_vld", out_vld, 0);
    chk("load_busy", busy, 1);
    chk("load_cmd_rdy", cmd_rdy, 0);
    tick();
    k = 0; cyc = 0; stalls = 0;
    while (k < nb && cyc < 4000) begin
      dst = (d0 + k) % 2048;
      tmp = (dst * 32 + delta) % 65536;
      rdw = tmp / 32;
      m = 32'hFFFF_FFFF;
      if (k == 0)      m = m & (32'hFFFF_FFFF << (d % 32));
      if (k == nb - 1) m = m & (32'hFFFF_FFFF >> (31 - e % 32));
      chk("beat_vld", out_vld, 1);
      chk("beat_cmd_rdy", cmd_rdy, 0);
      chk("beat_busy", busy, 1);
      chk("beat_first", first, (k == 0) ? 1 : 0);
      chk("beat_last", last, (k == nb - 1) ? 1 : 0);
      chk("beat_rad", rad, delta % 32);
      chk("beat_rd_adr", rd_adr, rdw);
      chk("beat_dst_adr", dst_adr, dst);
      chk("beat_msk", dst_msk, m);
      if (int'(k) == stall_at && int'(stalls) < stall_n) begin
        rdy = 1'b0;
        stalls++;
      end else if (rnd) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b1;
      end
      out_rdy = rdy;
      tick();
      cyc++;
      if (rdy) k++;
    end
    out_rdy = 1'b0;
    chk("beat_count", k, nb);
    chk("done_vld", out_vld, 0);
    chk("done_cmd_rdy", cmd_rdy, 1);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned rs, rd, rl;
    reset = 1'b1; cmd_vld = 1'b0; out_rdy = 1'b0;
    cmd_sadr = '0; cmd_dadr = '0; cmd_len = '0;
    tick();
    tick();
    chk("rst_vld", out_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_first", first, 0);
    chk("rst_last", last, 0);
    chk("rst_rad", rad, 0);
    chk("rst_rd_adr", rd_adr, 0);
    chk("rst_dst_adr", dst_adr, 0);
    chk("rst_msk", dst_msk, 0);
    reset = 1'b0;
    tick();

    // Aligned two-beat copy.
    issue(0, 0, 64);
    collect(0, 0, 64, -1, 0, 1'b0);

    // Unaligned, negative delta.
    issue(8, 36, 40);
    collect(8, 36, 40, -1, 0, 1'b0);

    // Single beat, large positive delta.
    issue(100, 5, 3);
    collect(100, 5, 3, -1, 0, 1'b0);

    // Backpressure on beat1 for 3 cycles.
    issue(0, 0, 128);
    collect(0, 0, 128, 1, 3, 1'b0);

    // Second command held valid during a run is accepted only afterwards.
    issue(8, 36, 40);
    cmd_sadr = 16'd0; cmd_dadr = 16'd0; cmd_len = 16'd64; cmd_vld = 1'b1;
    collect(8, 36, 40, -1, 0, 1'b0);
    tick();
    cmd_vld = 1'b0;
    collect(0, 0, 64, -1, 0, 1'b0);

    // Zero-length command is a no-op.
    issue(3, 7, 0);
    for (int i = 0; i < 4; i++) begin
      chk("nop_vld", out_vld, 0);
      chk("nop_busy", busy, 0);
      chk("nop_cmd_rdy", cmd_rdy, 1);
      tick();
    end

    // Destination and source word addresses wrapping at 2^WAW.
    issue(16'h0010, 16'hFFF0, 64);
    collect(16'h0010, 16'hFFF0, 64, 0, 2, 1'b0);

    // Reset in RUN after beat0 has been accepted.
    issue(0, 0, 64);
    chk("abort_load_vld", out_vld, 0);
    tick();
    chk("abort_b0_first", first, 1);
    out_rdy = 1'b1;
    tick();
    chk("abort_b1_vld", out_vld, 1);
    chk("abort_b1_last", last, 1);
    reset = 1'b1;
    out_rdy = 1'b0;
    tick();
    reset = 1'b0;
    chk("abort_vld", out_vld, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_rdy", cmd_rdy, 1);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_beat", out_vld, 0);
    end
    out_rdy = 1'b0;

    // Randomized commands with random backpressure.
    for (int i = 0; i < 25; i++) begin
      rs = $urandom_range(0, 65535);
      rd = $urandom_range(0, 65535);
      rl = $urandom_range(1, 300);
      issue(rs, rd, rl);
      collect(rs, rd, rl, -1, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
